uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Packet-level scheduler and serializer for the single shared UART TX pin.
- Two byte-stream requesters: ch0 is CROC debug text (high priority); ch1 is aging-monitor binary packets (low priority).
- Arbitration happens only at packet boundaries, so packets never interleave or collide. A starvation guard bounds ch1 wait time.
- Contains its own 8N1 transmitter. It replaces line-level sniffing of two independent UART outputs.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be ≥2.
- MAX_CONSEC, 4, max consecutive ch0 packets granted while ch1 is waiting.
- GAP_BITS, 2, idle bit-times (tx=1) inserted after every packet.
- TIMEOUT_CYCLES, 100000, FETCH stall limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch0_data  in  8  ch0 byte
- ch0_valid  in  1  ch0 byte valid
- ch0_last  in  1  ch0 byte is last of packet
- ch0_ready  out  1  ch0 byte accepted this cycle
- ch1_data  in  8  ch1 byte
- ch1_valid  in  1  ch1 byte valid
- ch1_last  in  1  ch1 byte is last of packet
- ch1_ready  out  1  ch1 byte accepted this cycle
- tx  out  1  UART serial output, idle high
- grant  out  2  one-hot current owner; 00 = none
- busy  out  1  state != IDLE
- timeout_flag  out  1  one-cycle pulse on packet abort

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: tx=1, grant=00, busy=0, ch0_ready=ch1_ready=0, timeout_flag=0, state=IDLE, consec_cnt=0.
- Reset mid-frame: tx returns to 1 immediately and asynchronously. The partial byte is lost.
- FSM states: IDLE, FETCH, SHIFT, GAP.
- IDLE, arbitration (registered):
  - ch0_valid only → grant ch0.
  - ch1_valid only → grant ch1.
  - Both valid → ch0, unless consec_cnt==MAX_CONSEC, in which case ch1.
  - Any grant → next state FETCH. Grant is visible the cycle after valid is seen.
- consec_cnt:
  - Granting ch0 while ch1_valid=1 → consec_cnt+1, saturating at MAX_CONSEC.
  - Granting ch1, or granting ch0 while ch1_valid=0 → consec_cnt cleared.
- FETCH:
  - chX_ready = (state==FETCH) & grant[X] & chX_valid, combinational. The non-granted channel's ready is always 0.
  - On handshake: latch data and last, go to SHIFT.
  - Requesters hold data/last stable while valid is high.
- SHIFT:
  - Frame is start bit (0), data[0]..data[7], stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
  - tx is driven from a register.
  - Start bit begins the cycle after the handshake.
  - At end of stop bit: go to GAP if latched last=1, else back to FETCH.
- GAP: tx=1 for GAP_BITS*CLKS_PER_BIT cycles, then grant=00 and state IDLE. Re-arbitration happens in IDLE.
- Simultaneous events:
  - Valid changes on the non-granted channel during a packet are ignored until IDLE.
  - A new valid arriving in the last GAP cycle is arbitrated on the next cycle.
- No timeout without the feature: FETCH waits indefinitely for the owner's next byte.
- Counter widths: bit counter 4 bits; baud counter $clog2(CLKS_PER_BIT); gap counter sized for GAP_BITS*CLKS_PER_BIT.

Optional Feature:
- Macro: UART_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in FETCH with the owner's valid=0. It clears on handshake or on leaving FETCH.
  - When it reaches TIMEOUT_CYCLES: timeout_flag=1 for one cycle, grant=00, state IDLE directly (no GAP).
  - consec_cnt is unchanged.
  - A byte already in SHIFT always completes.
- Without the macro: no counter is instantiated, timeout_flag is tied 0, and FETCH never aborts.

Test Plan (CLKS_PER_BIT=4, GAP_BITS=2, MAX_CONSEC=4, TIMEOUT_CYCLES=50):
1. ch1 sends 0x55 then 0xA3 (last=1) → grant=10, exactly 2 ch1_ready pulses, each frame 40 cycles LSB-first with 0xA3 bits 1,1,0,0,0,1,0,1, then 8 cycles tx=1, then grant=00 and busy=0.
2. ch0 and ch1 valid in the same IDLE cycle, 1-byte packets → ch0 frame first; ch1 granted immediately after ch0's 8-cycle gap; ch1_ready=0 throughout ch0's packet.
3. ch0 continuously presents 1-byte packets while ch1_valid held high → ch0 granted 4 times, 5th grant is ch1, consec_cnt returns to 0, then ch0 again.
4. Byte 0x00 on ch0 → tx low for exactly 36 cycles (start + 8 data), then high for the 4-cycle stop bit plus 8 gap cycles.
5. ch0 sends 0x41 (last=0) then drops valid → with UART_SCHED_TIMEOUT_EN: 50 cycles after the frame ends, timeout_flag pulses once, grant=00, busy=0. Without the macro: still in FETCH with grant=01 after 1000 cycles.
6. rst_n pulled low during data bit 3 of a frame → tx=1 in the same cycle without a clock edge; after release all outputs are at reset values and a new ch1 packet transmits correctly.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Packet-level arbiter and 8N1 serializer for two byte-stream requesters sharing one UART TX pin.
// Optional FETCH stall abort is compiled in with `define UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int MAX_CONSEC     = 4,
  parameter int GAP_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ch0_data,
  input  logic       ch0_valid,
  input  logic       ch0_last,
  output logic       ch0_ready,
  input  logic [7:0] ch1_data,
  input  logic       ch1_valid,
  input  logic       ch1_last,
  output logic       ch1_ready,
  output logic       tx,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_flag
);

  localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYCLES = (GAP_BITS * CLKS_PER_BIT > 0) ? GAP_BITS * CLKS_PER_BIT : 1;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int CONSEC_W   = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;

  localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC);
  localparam logic [3:0]          STOP_IDX   = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state;
  logic [CONSEC_W-1:0] consec_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          bit_idx;
  logic [GAP_W-1:0]    gap_cnt;
  logic [8:0]          shreg;
  logic                last_r;

  logic       pick0;
  logic       pick1;
  logic       handshake;
  logic [7:0] fetch_data;
  logic       fetch_last;
  logic       fetch_abort;

  // Handshake: a byte transfers on a rising edge where valid and ready are both high.
  // Ready is only offered to the current owner while in FETCH; requesters keep data/last
  // stable while valid is high and may only drop valid after the transfer.
  assign ch0_ready  = (state == FETCH) & grant[0] & ch0_valid;
  assign ch1_ready  = (state == FETCH) & grant[1] & ch1_valid;
  assign handshake  = ch0_ready | ch1_ready;
  assign fetch_data = grant[0] ? ch0_data : ch1_data;
  assign fetch_last = grant[0] ? ch0_last : ch1_last;
  assign busy       = (state != IDLE);

  // ch0 wins contention until it has been granted MAX_CONSEC times in a row over a waiting ch1.
  assign pick1 = ch1_valid & (~ch0_valid | (consec_cnt == CONSEC_MAX));
  assign pick0 = ch0_valid & ~pick1;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            owner_valid;
  logic            stalled;

  assign owner_valid = (grant[0] & ch0_valid) | (grant[1] & ch1_valid);
  assign stalled     = (state == FETCH) & ~owner_valid;
  assign fetch_abort = stalled & (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= fetch_abort;
      if (stalled && !fetch_abort) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  // Feature off: FETCH waits forever; constant 0 for any legal (positive) limit.
  assign fetch_abort  = (TIMEOUT_CYCLES < 1);
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 2'b00;
      consec_cnt <= '0;
      tx         <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= 4'd0;
      gap_cnt    <= '0;
      shreg      <= 9'h1ff;
      last_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pick0) begin
            grant <= 2'b01;
            state <= FETCH;
            if (!ch1_valid) begin
              consec_cnt <= '0;
            end else if (consec_cnt != CONSEC_MAX) begin
              consec_cnt <= consec_cnt + CONSEC_W'(1);
            end
          end else if (pick1) begin
            grant      <= 2'b10;
            state      <= FETCH;
            consec_cnt <= '0;
          end
        end

        FETCH: begin
          if (handshake) begin
            shreg    <= {1'b1, fetch_data};
            last_r   <= fetch_last;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
            state    <= SHIFT;
          end else if (fetch_abort) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end

        SHIFT: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
              gap_cnt <= '0;
              state   <= last_r ? GAP : FETCH;
            end else begin
              // shreg carries data LSB-first with the stop bit parked at the top.
              bit_idx <= bit_idx + 4'd1;
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[8:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        GAP: begin
          tx <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            grant <= 2'b00;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          grant <= 2'b00;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: queue-fed requesters, a UART frame decoder and
// grant logger feed scoreboards compared against hand-computed expectations.
module tb_uart_tx_scheduler;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ch0_data, ch1_data;
  logic       ch0_valid, ch1_valid, ch0_last, ch1_last;
  logic       ch0_ready, ch1_ready;
  logic       tx, busy, timeout_flag;
  logic [1:0] grant;

  int checks = 0;
  int failures = 0;

  logic [8:0]  ch0_src_q[$];
  logic [8:0]  ch1_src_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] rx_q[$];
  logic [4:0]  exp_g_q[$];
  logic [4:0]  grant_q[$];

  int hs0_cnt = 0;
  int hs1_cnt = 0;
  int bad_ready = 0;
  int tf_cnt = 0;

  uart_tx_scheduler #(
    .CLKS_PER_BIT(CPB),
    .MAX_CONSEC(4),
    .GAP_BITS(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch0_data(ch0_data),
    .ch0_valid(ch0_valid),
    .ch0_last(ch0_last),
    .ch0_ready(ch0_ready),
    .ch1_data(ch1_data),
    .ch1_valid(ch1_valid),
    .ch1_last(ch1_last),
    .ch1_ready(ch1_ready),
    .tx(tx),
    .grant(grant),
    .busy(busy),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // Requesters: present the queue head, pop it after a handshake.
  initial begin : feed0
    logic take;
    ch0_valid = 1'b0; ch0_data = 8'h00; ch0_last = 1'b0;
    forever begin
      @(negedge clk);
      take = ch0_valid && ch0_ready;
      @(posedge clk);
      #1;
      if (take && ch0_src_q.size() > 0) void'(ch0_src_q.pop_front());
      if (ch0_src_q.size() > 0) begin
        ch0_valid = 1'b1;
        {ch0_last, ch0_data} = ch0_src_q[0];
      end else begin
        ch0_valid = 1'b0;
      end
    end
  end

  initial begin : feed1
    logic take;
    ch1_valid = 1'b0; ch1_data = 8'h00; ch1_last = 1'b0;
    forever begin
      @(negedge clk);
      take = ch1_valid && ch1_ready;
      @(posedge clk);
      #1;
      if (take && ch1_src_q.size() > 0) void'(ch1_src_q.pop_front());
      if (ch1_src_q.size() > 0) begin
        ch1_valid = 1'b1;
        {ch1_last, ch1_data} = ch1_src_q[0];
      end else begin
        ch1_valid = 1'b0;
      end
    end
  end

  // Line decoder and grant logger: frames become {start_ok, stop, grant, byte}.
  int         mon_cnt = -1;
  logic [7:0] mon_sh = 8'h00;
  logic [1:0] mon_gr = 2'b00;
  logic       mon_start_ok = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  always @(negedge clk) begin
    if (ch0_valid && ch0_ready) hs0_cnt++;
    if (ch1_valid && ch1_ready) hs1_cnt++;
    if ((ch0_ready && grant != 2'b01) || (ch1_ready && grant != 2'b10)) bad_ready++;
    if (timeout_flag) tf_cnt++;
    if (grant != prev_grant && grant != 2'b00) grant_q.push_back({dut.consec_cnt, grant});
    prev_grant = grant;
    if (!rst_n) begin
      mon_cnt = -1;
    end else if (mon_cnt < 0) begin
      if (tx === 1'b0) begin
        mon_cnt = 0;
        mon_gr = grant;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        mon_start_ok = (tx === 1'b0);
      end else if ((mon_cnt % CPB) == 2 && mon_cnt < 9 * CPB) begin
        mon_sh = {tx, mon_sh[7:1]};
      end else if (mon_cnt == 9 * CPB + 2) begin
        rx_q.push_back({mon_start_ok, tx, mon_gr, mon_sh});
        mon_cnt = -1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_frame_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_grant_count"}, grant_q.size(), exp_g_q.size());
    while (grant_q.size() > 0 && exp_g_q.size() > 0)
      check({tag, "_grant"}, grant_q.pop_front(), exp_g_q.pop_front());
    grant_q.delete();
    exp_g_q.delete();
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(ch0_src_q.size() == 0 && ch1_src_q.size() == 0 &&
                           !busy && !ch0_valid && !ch1_valid)) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget), 1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g, input int budget);
    int n = 0;
    while (n < budget && grant !== g) begin
      @(negedge clk);
      n++;
    end
    check(tag, grant, g);
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < budget && tx !== 1'b0);
    check(tag, tx, 1'b0);
  endtask

  initial begin : stim
    int h1, lo, hi, tf0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", {ch0_ready, ch1_ready}, 2'b00);
    check("rst_timeout", timeout_flag, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 1: ch1 two-byte packet
    h1 = hs1_cnt;
    ch1_src_q.push_back({1'b0, 8'h55});
    ch1_src_q.push_back({1'b1, 8'hA3});
    exp_q.push_back({1'b1, 1'b1, 2'b10, 8'h55});
    exp_q.push_back({1'b1, 1'b1, 2'b10, 8'hA3});
    exp_g_q.push_back({3'd0, 2'b10});
    wait_quiet("t1_done", 400);
    check("t1_ready_pulses", hs1_cnt - h1, 2);
    check("t1_grant_end", grant, 2'b00);
    check("t1_busy_end", busy, 1'b0);
    check("t1_tx_idle", tx, 1'b1);
    check_rx("t1");
    check_grants("t1");

    // 2: simultaneous requests, ch0 first, ch1 right after the gap
    ch0_src_q.push_back({1'b1, 8'h3C});
    ch1_src_q.push_back({1'b1, 8'hC5});
    exp_q.push_back({1'b1, 1'b1, 2'b01, 8'h3C});
    exp_q.push_back({1'b1, 1'b1, 2'b10, 8'hC5});
    exp_g_q.push_back({3'd1, 2'b01});
    exp_g_q.push_back({3'd0, 2'b10});
    wait_grant("t2_ch0_grant", 2'b01, 20);
    wait_grant("t2_release", 2'b00, 100);
    @(negedge clk);
    check("t2_ch1_next", grant, 2'b10);
    wait_quiet("t2_done", 400);
    check("t2_bad_ready", bad_ready, 0);
    check_rx("t2");
    check_grants("t2");

    // 3: ch0 streaming while ch1 waits -> starvation guard after 4 grants
    ch1_src_q.push_back({1'b1, 8'h11});
    for (int i = 0; i < 6; i++) ch0_src_q.push_back({1'b1, 8'h20 + 8'(i)});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 1'b1, 2'b01, 8'h20 + 8'(i)});
      exp_g_q.push_back({3'(i + 1), 2'b01});
    end
    exp_q.push_back({1'b1, 1'b1, 2'b10, 8'h11});
    exp_g_q.push_back({3'd0, 2'b10});
    for (int i = 4; i < 6; i++) begin
      exp_q.push_back({1'b1, 1'b1, 2'b01, 8'h20 + 8'(i)});
      exp_g_q.push_back({3'd0, 2'b01});
    end
    wait_quiet("t3_done", 800);
    check("t3_bad_ready", bad_ready, 0);
    check_rx("t3");
    check_grants("t3");

    // 4: 0x00 frame shape and gap length
    ch0_src_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 1'b1, 2'b01, 8'h00});
    exp_g_q.push_back({3'd0, 2'b01});
    wait_tx_low("t4_start", 20);
    lo = 0;
    while (tx === 1'b0 && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    check("t4_low_cycles", lo, 36);
    hi = 0;
    while (busy && tx === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("t4_stop_gap_cycles", hi, 12);
    check("t4_grant_released", grant, 2'b00);
    wait_quiet("t4_done", 50);
    check_rx("t4");
    check_grants("t4");

    // 5: owner stalls mid-packet
    tf0 = tf_cnt;
    ch0_src_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b1, 1'b1, 2'b01, 8'h41});
    exp_g_q.push_back({3'd0, 2'b01});
    wait_tx_low("t5_start", 20);
`ifdef UART_SCHED_TIMEOUT_EN
    lo = 0;
    while (!timeout_flag && lo < 300) begin
      @(negedge clk);
      lo++;
    end
    check("t5_timeout_delay", lo, 90);
    check("t5_grant_abort", grant, 2'b00);
    check("t5_busy_abort", busy, 1'b0);
    @(negedge clk);
    check("t5_pulse_width", timeout_flag, 1'b0);
    check("t5_pulse_count", tf_cnt - tf0, 1);
`else
    repeat (1040) @(negedge clk);
    check("t5_still_granted", grant, 2'b01);
    check("t5_still_busy", busy, 1'b1);
    check("t5_tx_idle", tx, 1'b1);
    check("t5_no_timeout", tf_cnt - tf0, 0);
    ch0_src_q.push_back({1'b1, 8'h42});
    exp_q.push_back({1'b1, 1'b1, 2'b01, 8'h42});
    wait_quiet("t5_done", 200);
`endif
    check_rx("t5");
    check_grants("t5");

    // 6: asynchronous reset during data bit 3
    ch1_src_q.push_back({1'b1, 8'h96});
    exp_g_q.push_back({3'd0, 2'b10});
    wait_tx_low("t6_start", 20);
    repeat (17) @(negedge clk);
    check("t6_bit3_low", tx, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_tx", tx, 1'b1);
    check("t6_async_grant", grant, 2'b00);
    check("t6_async_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_tx", tx, 1'b1);
    check("t6_post_grant", grant, 2'b00);
    check("t6_post_busy", busy, 1'b0);
    check("t6_post_ready", {ch0_ready, ch1_ready}, 2'b00);
    check("t6_post_timeout", timeout_flag, 1'b0);
    ch1_src_q.push_back({1'b0, 8'h5A});
    ch1_src_q.push_back({1'b1, 8'hE7});
    exp_q.push_back({1'b1, 1'b1, 2'b10, 8'h5A});
    exp_q.push_back({1'b1, 1'b1, 2'b10, 8'hE7});
    exp_g_q.push_back({3'd0, 2'b10});
    wait_quiet("t6_done", 400);
    check_rx("t6");
    check_grants("t6");
    check("final_bad_ready", bad_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
